// File: rtl/sm_fx_pkg.sv
// Shared types and helpers for the sign-magnitude fixed-point MAC.
// Default word geometry is Q3.12 with four accumulator guard bits.
package sm_fx_pkg;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        DONE
    } state_t;

    localparam int W_DEF     = 16;
    localparam int FRAC_DEF  = 12;
    localparam int GUARD_DEF = 4;
    localparam int TERMS_DEF = 64;

    localparam int ACC_W   = W_DEF + GUARD_DEF;
    localparam int MAG_MAX = (1 << (W_DEF - 1)) - 1;

    // Magnitudes are carried at a fixed wide width so one helper serves any geometry.
    localparam int SM_MW = 64;

    typedef struct packed {
        logic             sat;
        logic             sign;
        logic [SM_MW-1:0] mag;
    } sm_sum_t;

    function automatic sm_sum_t sm_add(
        input logic             a_sign,
        input logic [SM_MW-1:0] a_mag,
        input logic             b_sign,
        input logic [SM_MW-1:0] b_mag,
        input int unsigned      mag_w
    );
        sm_sum_t          r;
        logic [SM_MW:0]   sum;
        logic [SM_MW:0]   lim;
        r   = '0;
        lim = ({{SM_MW{1'b0}}, 1'b1} << mag_w) - {{SM_MW{1'b0}}, 1'b1};
        if (a_sign == b_sign) begin
            sum    = {1'b0, a_mag} + {1'b0, b_mag};
            r.sign = a_sign;
            if (sum > lim) begin
                r.sat = 1'b1;
                r.mag = lim[SM_MW-1:0];
            end else begin
                r.mag = sum[SM_MW-1:0];
            end
        end else if (a_mag >= b_mag) begin
            r.sign = a_sign;
            r.mag  = a_mag - b_mag;
        end else begin
            r.sign = b_sign;
            r.mag  = b_mag - a_mag;
        end
        if (r.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_fx_mul.sv
// Registered stage-1 sign-magnitude multiplier: product, FRAC shift,
// clamp to the accumulator magnitude range and -0 suppression.
module sm_fx_mul
    import sm_fx_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int AM   = W_DEF - 1 + GUARD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  w,
    output logic          p_valid,
    output logic          p_sign,
    output logic [AM-1:0] p_mag,
    output logic          p_ovf
);

    localparam int PW = 2 * (W - 1);

    logic [PW-1:0]    prod;
    logic [PW-1:0]    shifted;
    logic [SM_MW-1:0] wide;
    logic [SM_MW-1:0] lim;
    logic             clamp;
    logic [AM-1:0]    mag;

    always_comb begin
        prod    = {{(W-1){1'b0}}, x[W-2:0]} * {{(W-1){1'b0}}, w[W-2:0]};
        shifted = prod >> FRAC;
        wide    = SM_MW'(shifted);
        lim     = (SM_MW'(1) << AM) - SM_MW'(1);
        clamp   = wide > lim;
        mag     = clamp ? lim[AM-1:0] : wide[AM-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_sign  <= 1'b0;
            p_mag   <= '0;
            p_ovf   <= 1'b0;
        end else begin
            p_valid <= en;
            if (en) begin
                p_sign <= (x[W-1] ^ w[W-1]) & (mag != '0);
                p_mag  <= mag;
                p_ovf  <= clamp;
            end
        end
    end

endmodule

// File: rtl/sm_fx_mac.sv
// Pipelined sign-magnitude fixed-point multiply-accumulate for neuron sums:
// stage-1 multiply, stage-2 guarded accumulate, saturated result per vector.
module sm_fx_mac
    import sm_fx_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int FRAC      = FRAC_DEF,
    parameter int GUARD     = GUARD_DEF,
    parameter int MAX_TERMS = TERMS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_x,
    input  logic [W-1:0]                   in_w,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [W-1:0]                   out_result,
    output logic                           out_ovf,
    output logic [$clog2(MAX_TERMS+1)-1:0] out_terms
);

    localparam int AM    = W - 1 + GUARD;
    localparam int CW    = $clog2(MAX_TERMS + 1);
    localparam int OUT_M = (1 << (W - 1)) - 1;

    state_t state;
    state_t state_nx;

    logic          accept;
    logic          end_vec;
    logic          handshake;
    logic [CW-1:0] terms;

    logic          p_valid;
    logic          p_sign;
    logic [AM-1:0] p_mag;
    logic          p_ovf;

    logic          acc_sign;
    logic [AM-1:0] acc_mag;
    logic          acc_ovf;
    sm_sum_t       add_r;
    logic          add_hi;
    logic          acc_big;
    logic [W-1:0]  fmt;

    assign accept    = in_valid & in_ready;
    assign end_vec   = in_last | (terms == CW'(MAX_TERMS - 1));
    assign handshake = out_valid & out_ready;

    sm_fx_mul #(
        .W    (W),
        .FRAC (FRAC),
        .AM   (AM)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .x       (in_x),
        .w       (in_w),
        .p_valid (p_valid),
        .p_sign  (p_sign),
        .p_mag   (p_mag),
        .p_ovf   (p_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        unique case (state)
            ACC: begin
                in_ready = 1'b1;
                if (accept && end_vec) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = DONE;
            end
            DONE: begin
                if (handshake) begin
                    state_nx = ACC;
                end
            end
            default: begin
                state_nx = ACC;
            end
        endcase
    end

    always_comb begin
        add_r   = sm_add(acc_sign, SM_MW'(acc_mag), p_sign, SM_MW'(p_mag), AM);
        add_hi  = |add_r.mag[SM_MW-1:AM];
        acc_big = acc_mag > AM'(OUT_M);
        fmt     = acc_big ? {acc_sign, {(W-1){1'b1}}}
                          : {acc_sign, acc_mag[W-2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            acc_ovf  <= 1'b0;
            terms    <= '0;
        end else if (state == DONE && handshake) begin
            acc_sign <= 1'b0;
            acc_mag  <= '0;
            acc_ovf  <= 1'b0;
            terms    <= '0;
        end else begin
            if (accept) begin
                terms <= terms + CW'(1);
            end
            if (p_valid) begin
                acc_sign <= add_r.sign;
                acc_mag  <= add_r.mag[AM-1:0];
                acc_ovf  <= acc_ovf | p_ovf | add_r.sat | add_hi;
            end
        end
    end

    // Result is captured one edge after DONE is entered, so it is stable
    // for as long as the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_terms  <= '0;
        end else if (state == DONE) begin
            if (!out_valid) begin
                out_valid  <= 1'b1;
                out_result <= fmt;
                out_ovf    <= acc_ovf | acc_big;
                out_terms  <= terms;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_fx_mac.sv
// Directed self-checking bench for sm_fx_mac (Q3.12, MAX_TERMS=4).
module tb_sm_fx_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_ovf;
    logic [2:0]  out_terms;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_fx_mac #(
        .W         (16),
        .FRAC      (12),
        .GUARD     (4),
        .MAX_TERMS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_w       (in_w),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_terms  (out_terms)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] w,
                        input logic last);
        bit done;
        bit rdy;
        done     = 1'b0;
        in_x     = x;
        in_w     = w;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get(input string tag, input logic [15:0] res,
                       input logic ovf, input logic [2:0] n);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(res));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
        check({tag, "_terms"}, 32'(out_terms), 32'(n));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_terms", 32'(out_terms), 32'd0);

        // cancellation and latency: +0.5 then -0.5
        send(16'h1000, 16'h0800, 1'b0);
        send(16'h8800, 16'h1000, 1'b1);
        check("lat_k0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_k1", 32'(out_valid), 32'd0);
        check("lat_k1_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("lat_k2", 32'(out_valid), 32'd1);
        get("cancel", 16'h0000, 1'b0, 3'd2);

        // signed mix under backpressure: -1.5 + 0.125
        send(16'h2000, 16'h8C00, 1'b0);
        send(16'h0800, 16'h0400, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        in_x     = 16'h7FFF;
        in_w     = 16'h7FFF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(out_result), 32'h9600);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        get("mix", 16'h9600, 1'b0, 3'd2);

        // saturation: 4 x 7.0 = 28.0, then recovery
        for (int i = 0; i < 4; i++) send(16'h7000, 16'h1000, i == 3);
        get("sat", 16'h7FFF, 1'b1, 3'd4);
        send(16'h1000, 16'h1000, 1'b1);
        get("post_sat", 16'h1000, 1'b0, 3'd1);

        // underflowing product must not yield -0
        send(16'h8001, 16'h0001, 1'b1);
        get("neg_zero", 16'h0000, 1'b0, 3'd1);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_valid", 32'(out_valid), 32'd0);
        check("idle_ready_in", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // forced end at MAX_TERMS, remainder starts a new vector
        for (int i = 0; i < 4; i++) send(16'h1000, 16'h1000, 1'b0);
        get("forced", 16'h4000, 1'b0, 3'd4);
        send(16'h1000, 16'h1000, 1'b0);
        send(16'h1000, 16'h1000, 1'b0);
        send(16'h1000, 16'h1000, 1'b1);
        get("remain", 16'h3000, 1'b0, 3'd3);

        // reset mid-vector
        for (int i = 0; i < 3; i++) send(16'h7000, 16'h7000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_ovf", 32'(out_ovf), 32'd0);
        check("mid_rst_terms", 32'(out_terms), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        send(16'h0800, 16'h0800, 1'b1);
        get("after_rst", 16'h0400, 1'b0, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
